nibble_sum_sched: RTL and testbench
===================================

Name: nibble_sum_sched

Overview:
- Scheduler and sequencer for the nibble-sum engine (16-bit load, then three 4-bit+4-bit sums selected by a 2-bit sel).
- Shares one engine between two requesters using round-robin arbitration.
- Drives the engine's d and sel through the load/sum sequence and collects the three 5-bit sums.
- Returns one packed result per accepted word, tagged with the requester id, over a valid/ready handshake.

Parameters:
- RR_INIT, 0, requester that wins the first tie after reset (0 or 1).
- CHK_EN, 1, when 1, checks the engine's validout against the expected sequence and raises the sticky err flag on mismatch.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- req0_valid  input  1  requester 0 has a word.
- req0_data  input  16  requester 0 word.
- req0_ready  output  1  requester 0 word accepted this cycle.
- req1_valid  input  1  requester 1 has a word.
- req1_data  input  16  requester 1 word.
- req1_ready  output  1  requester 1 word accepted this cycle.
- cal_d  output  16  engine data input.
- cal_sel  output  2  engine select: 00 load, 01/10/11 sum of nibble 0 with nibble 1/2/3.
- cal_out  input  5  engine registered sum.
- cal_valid  input  1  engine validout.
- res_valid  output  1  result available.
- res_ready  input  1  consumer accepts the result.
- res_data  output  15  {sum3, sum2, sum1}; sumN = nibble0 + nibbleN.
- res_id  output  1  requester that supplied the word.
- busy  output  1  high in every state except IDLE.
- err  output  1  sticky engine-sequence error.

Behaviour:
- Reset (async, rst=0):
  - state=IDLE.
  - All outputs 0; word register 0, so cal_d=0 and cal_sel=00.
  - Round-robin pointer set so requester RR_INIT wins the first tie.
  - Result and err cleared.
  - A reset mid-sequence aborts the sequence: no result is emitted and no ready is pulsed.
- FSM states: IDLE, LOAD, SUM1, SUM2, SUM3, WAIT, DONE. Transitions are unconditional except IDLE and DONE.
- IDLE:
  - If any reqN_valid, grant one requester. With a single valid, that requester wins. With both valid, the requester not served last wins.
  - reqN_ready=1 combinationally for the granted requester only, in IDLE only.
  - On that edge: capture the word and the id, update the pointer, go to LOAD.
- cal_d always equals the captured word register.
- cal_sel is decoded from the state register: SUM1=01, SUM2=10, SUM3=11, every other state=00.
- Engine output latency is one cycle, so sums are captured as follows:
  - end of SUM2: sum1 = cal_out
  - end of SUM3: sum2 = cal_out
  - end of WAIT: sum3 = cal_out
  - After WAIT, go to DONE.
- DONE:
  - res_valid=1; res_data and res_id are held stable while res_valid=1.
  - On res_valid & res_ready, go to IDLE and deassert res_valid on that edge.
  - Backpressure is unlimited. No new word is accepted until the result is taken.
- Minimum period is 7 cycles per word (IDLE → DONE accepted). busy=0 only in IDLE.
- Width rule: each sum is 5 bits, range 0..30, with no truncation. res_data[4:0]=sum1, [9:5]=sum2, [14:10]=sum3.
- Checking (CHK_EN=1):
  - cal_valid must be 1 in SUM2, SUM3 and WAIT.
  - Any 0 sampled there sets err on that edge. err stays set until reset.
  - The sequence still completes and the result is still delivered.
  - With CHK_EN=0, err stays 0.
- Simultaneous events: a requester dropping valid in the same cycle it would be granted has no effect, because the grant uses the same-cycle valid. A new request arriving in DONE waits in IDLE.

Test Plan:
- Reset, then req0 sends 0x4321 → req0_ready pulses one cycle; cal_sel sequence 00,01,10,11,00; in DONE res_data={5'd5,5'd4,5'd3}=0x1483, res_id=0, err=0.
- req1 sends 0xFFFF with res_ready held 1 → res_data={30,30,30}=0x7BDE, res_id=1, res_valid high for one cycle, busy back to 0 the following cycle.
- Both valid continuously with RR_INIT=0, words 0x1111 (req0) and 0x2222 (req1) → grants alternate 0,1,0,1; results 0x0842 (id 0) and 0x1084 (id 1).
- res_ready held 0 for 20 cycles in DONE → res_valid and res_data stable, req ready stays 0 throughout; on res_ready=1, the next grant happens one cycle after the return to IDLE.
- Engine model forces cal_valid=0 in SUM3 → err=1 from the next edge and stays 1; the result is still delivered; err clears only on rst.
- rst asserted during SUM2 → all outputs 0 immediately; no result; after release, the first tie goes to RR_INIT.

Source files
------------

// File: rtl/nibble_sum_sched.sv
// -----------------------------------------------------------------------------
// nibble_sum_sched
//
// Shares one nibble-sum engine between two requesters. A granted 16-bit word
// is loaded into the engine (sel=00) and then three sums are requested
// (sel=01/10/11). Each sum adds nibble 0 to nibble 1, 2 or 3. The registered
// sums are collected and returned as one packed result, tagged with the id of
// the requester that supplied the word.
//
// Handshake semantics (all three channels): a transfer happens on a rising
// edge where valid and ready are both 1. On the request side, ready is
// combinational from the same-cycle valid and is only ever asserted in IDLE.
// On the result side, res_valid is registered and stays high, with res_data
// and res_id held stable, until the consumer returns res_ready.
//
// Parameters:
//   RR_INIT  requester (0/1) that wins the first tie after reset
//   CHK_EN   1: compare engine validout with the expected sequence, set err
//
// Ports:
//   clk         clock, rising edge
//   rst         asynchronous active-low reset
//   req0_valid  requester 0 has a word       req0_data  requester 0 word
//   req0_ready  requester 0 word accepted this cycle
//   req1_valid  requester 1 has a word       req1_data  requester 1 word
//   req1_ready  requester 1 word accepted this cycle
//   cal_d       engine data input (the captured word)
//   cal_sel     engine select: 00 load, 01/10/11 nibble0 + nibble1/2/3
//   cal_out     engine registered 5-bit sum
//   cal_valid   engine validout
//   res_valid   result available             res_ready  consumer accepts
//   res_data    {sum3, sum2, sum1}, 5 bits each
//   res_id      requester that supplied the word
//   busy        high in every state except IDLE
//   err         sticky engine-sequence error
//   state_dbg   current FSM state, for observation only
// -----------------------------------------------------------------------------
module nibble_sum_sched #(
    parameter int unsigned RR_INIT = 0,
    parameter int unsigned CHK_EN  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    input  logic [15:0] req0_data,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [15:0] req1_data,
    output logic        req1_ready,
    output logic [15:0] cal_d,
    output logic [1:0]  cal_sel,
    input  logic [4:0]  cal_out,
    input  logic        cal_valid,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [14:0] res_data,
    output logic        res_id,
    output logic        busy,
    output logic        err,
    output logic [2:0]  state_dbg
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_SUM1 = 3'd2;
    localparam logic [2:0] S_SUM2 = 3'd3;
    localparam logic [2:0] S_SUM3 = 3'd4;
    localparam logic [2:0] S_WAIT = 3'd5;
    localparam logic [2:0] S_DONE = 3'd6;

    logic [2:0]  state_q;
    logic [2:0]  state_nxt;
    logic [15:0] word_q;
    logic        id_q;
    logic        prio_q;      // requester that wins the next tie
    logic [4:0]  sum1_q;
    logic [4:0]  sum2_q;
    logic [4:0]  sum3_q;
    logic        err_q;

    logic        gnt0;
    logic        gnt1;
    logic        idle_ok;
    logic        chk_window;

    // -------------------------------------------------------------------------
    // Arbitration. Ready is gated by rst so that nothing is accepted while the
    // block is held in reset, even though the state register already reads
    // IDLE.
    // -------------------------------------------------------------------------
    assign idle_ok = (state_q == S_IDLE) && rst;

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (idle_ok) begin
            if (req0_valid && req1_valid) begin
                gnt0 = (prio_q == 1'b0);
                gnt1 = (prio_q == 1'b1);
            end else begin
                gnt0 = req0_valid;
                gnt1 = req1_valid;
            end
        end
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;

    // -------------------------------------------------------------------------
    // Next-state logic. Only IDLE and DONE wait on inputs; the engine
    // sequence itself is fixed length.
    // -------------------------------------------------------------------------
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            S_IDLE: if (gnt0 || gnt1) state_nxt = S_LOAD;
            S_LOAD: state_nxt = S_SUM1;
            S_SUM1: state_nxt = S_SUM2;
            S_SUM2: state_nxt = S_SUM3;
            S_SUM3: state_nxt = S_WAIT;
            S_WAIT: state_nxt = S_DONE;
            S_DONE: if (res_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // The engine registers its sum, so each sum appears one state after the
    // select that requested it: SUM2/SUM3/WAIT are the cycles in which the
    // engine must present a valid sum.
    assign chk_window = (state_q == S_SUM2) || (state_q == S_SUM3) ||
                        (state_q == S_WAIT);

    // -------------------------------------------------------------------------
    // Sequential state
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            word_q  <= 16'h0000;
            id_q    <= 1'b0;
            prio_q  <= 1'(RR_INIT);
            sum1_q  <= 5'd0;
            sum2_q  <= 5'd0;
            sum3_q  <= 5'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_nxt;

            if (gnt0 || gnt1) begin
                word_q <= gnt1 ? req1_data : req0_data;
                id_q   <= gnt1;
                // The requester just served loses the next tie.
                prio_q <= ~gnt1;
            end

            case (state_q)
                S_SUM2:  sum1_q <= cal_out;
                S_SUM3:  sum2_q <= cal_out;
                S_WAIT:  sum3_q <= cal_out;
                default: ;
            endcase

            // A missing validout is recorded but does not stall or abort the
            // sequence; the result is delivered regardless.
            if ((CHK_EN != 0) && chk_window && !cal_valid) begin
                err_q <= 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign cal_d = word_q;

    always_comb begin
        cal_sel = 2'b00;
        case (state_q)
            S_SUM1:  cal_sel = 2'b01;
            S_SUM2:  cal_sel = 2'b10;
            S_SUM3:  cal_sel = 2'b11;
            default: cal_sel = 2'b00;
        endcase
    end

    // Result registers only change in SUM2..WAIT, so they are naturally
    // stable for as long as DONE is held by backpressure.
    assign res_valid = (state_q == S_DONE);
    assign res_data  = {sum3_q, sum2_q, sum1_q};
    assign res_id    = id_q;
    assign busy      = (state_q != S_IDLE);
    assign err       = err_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_nibble_sum_sched.sv
// -----------------------------------------------------------------------------
// Testbench for nibble_sum_sched. Includes a behavioural nibble-sum engine:
// sel=00 loads d, sel!=00 registers nibble0 + nibbleN with validout=1.
// -----------------------------------------------------------------------------
module tb_nibble_sum_sched;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        req0_valid = 1'b0;
  logic [15:0] req0_data  = 16'h0000;
  logic        req0_ready;
  logic        req1_valid = 1'b0;
  logic [15:0] req1_data  = 16'h0000;
  logic        req1_ready;
  logic [15:0] cal_d;
  logic [1:0]  cal_sel;
  logic [4:0]  cal_out;
  logic        cal_valid;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [14:0] res_data;
  logic        res_id;
  logic        busy;
  logic        err;
  logic [2:0]  state_dbg;

  nibble_sum_sched #(.RR_INIT(0), .CHK_EN(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .cal_d      (cal_d),
    .cal_sel    (cal_sel),
    .cal_out    (cal_out),
    .cal_valid  (cal_valid),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_id     (res_id),
    .busy       (busy),
    .err        (err),
    .state_dbg  (state_dbg)
  );

  // ---------------------------------------------------------------------------
  // Engine model
  // ---------------------------------------------------------------------------
  logic [15:0] eng_word;
  logic [4:0]  eng_out;
  logic        eng_v;
  logic        kill_en = 1'b0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      eng_word <= 16'h0000;
      eng_out  <= 5'd0;
      eng_v    <= 1'b0;
    end else begin
      case (cal_sel)
        2'b00: begin eng_word <= cal_d; eng_v <= 1'b0; end
        2'b01: begin eng_out <= {1'b0, eng_word[3:0]} + {1'b0, eng_word[7:4]};   eng_v <= 1'b1; end
        2'b10: begin eng_out <= {1'b0, eng_word[3:0]} + {1'b0, eng_word[11:8]};  eng_v <= 1'b1; end
        default: begin eng_out <= {1'b0, eng_word[3:0]} + {1'b0, eng_word[15:12]}; eng_v <= 1'b1; end
      endcase
    end
  end

  assign cal_out   = eng_out;
  assign cal_valid = eng_v & ~(kill_en & (cal_sel == 2'b11));

  // ---------------------------------------------------------------------------
  // Scoreboard: {id, sum3, sum2, sum1}
  // ---------------------------------------------------------------------------
  logic [15:0] exp_q[$];
  logic [15:0] obs_q[$];
  int checks = 0;
  int errors = 0;

  function automatic logic [15:0] model(input logic id, input logic [15:0] w);
    logic [4:0] s1, s2, s3;
    s1 = 5'(w[3:0]) + 5'(w[7:4]);
    s2 = 5'(w[3:0]) + 5'(w[11:8]);
    s3 = 5'(w[3:0]) + 5'(w[15:12]);
    return {id, s3, s2, s1};
  endfunction

  always @(negedge clk) begin
    if (rst && res_valid && res_ready) obs_q.push_back({res_id, res_data});
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Call at posedge+1. Returns at posedge+1 after the accepting edge.
  task automatic drive_req(input logic id, input logic [15:0] w, output bit ok);
    ok = 1'b0;
    if (id) begin req1_valid = 1'b1; req1_data = w; end
    else    begin req0_valid = 1'b1; req0_data = w; end
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if ((id ? req1_ready : req0_ready) === 1'b1) begin
        ok = 1'b1;
        exp_q.push_back(model(id, w));
        break;
      end
    end
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic wait_obs(input int n, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (obs_q.size() >= n) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b0;
    req0_valid = 1'b1;
    req0_data  = 16'hABCD;
    repeat (2) @(negedge clk);
    checks++;
    if ({req0_ready, req1_ready, res_valid, busy, err, res_id} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b required 000000",
               {req0_ready, req1_ready, res_valid, busy, err, res_id});
    end
    checks++;
    if (cal_d !== 16'h0 || cal_sel !== 2'b00 || res_data !== 15'h0) begin
      errors++;
      $display("FAIL reset_data: cal_d=%h cal_sel=%b res_data=%h required all 0",
               cal_d, cal_sel, res_data);
    end
    req0_valid = 1'b0;
    rst = 1'b1;
    tick();
  endtask

  task automatic test_single_req0();
    bit ok;
    logic [1:0] sel_exp[5];
    logic [15:0] got, want;
    sel_exp = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00};
    res_ready = 1'b0;
    drive_req(1'b0, 16'h4321, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL single_grant: got no req0_ready, required one"); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (cal_sel !== sel_exp[i] || req0_ready !== 1'b0) begin
        errors++;
        $display("FAIL single_sel[%0d]: got sel=%b ready=%b required sel=%b ready=0",
                 i, cal_sel, req0_ready, sel_exp[i]);
      end
    end
    @(negedge clk);
    checks++;
    if (res_valid !== 1'b1 || res_data !== 15'h1483 || res_id !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL single_done: got v=%b data=%h id=%b err=%b required v=1 data=1483 id=0 err=0",
               res_valid, res_data, res_id, err);
    end
    tick();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    wait_obs(1, ok);
    checks++;
    if (!ok || exp_q.size() == 0) begin
      errors++; $display("FAIL single_sb: got no result, required one");
    end else begin
      got = obs_q.pop_front(); want = exp_q.pop_front();
      if (got !== want) begin errors++; $display("FAIL single_sb: got %h required %h", got, want); end
    end
    @(negedge clk);
    checks++;
    if (res_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL single_idle: got v=%b busy=%b required 0 0", res_valid, busy);
    end
  endtask

  task automatic test_ready_held();
    bit ok;
    int cycles;
    logic [15:0] got, want;
    tick();
    res_ready = 1'b1;
    drive_req(1'b1, 16'hFFFF, ok);
    cycles = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      cycles++;
      if (res_valid === 1'b1) break;
    end
    checks++;
    if (!ok || cycles != 6) begin
      errors++; $display("FAIL held_latency: got ok=%0d cycles=%0d required 1 6", ok, cycles);
    end
    checks++;
    if (res_data !== 15'h7BDE || res_id !== 1'b1) begin
      errors++; $display("FAIL held_data: got %h id=%b required 7bde id=1", res_data, res_id);
    end
    @(negedge clk);
    checks++;
    if (res_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL held_oneshot: got v=%b busy=%b required 0 0", res_valid, busy);
    end
    wait_obs(1, ok);
    checks++;
    if (!ok || exp_q.size() == 0) begin
      errors++; $display("FAIL held_sb: got no result, required one");
    end else begin
      got = obs_q.pop_front(); want = exp_q.pop_front();
      if (got !== want) begin errors++; $display("FAIL held_sb: got %h required %h", got, want); end
    end
  endtask

  task automatic test_round_robin();
    bit ok;
    int g;
    logic [3:0] ids;
    logic [3:0] exp_ids;
    logic [15:0] got, want;
    exp_ids = 4'b1010;
    ids = 4'b0000;
    g = 0;
    tick();
    res_ready  = 1'b1;
    req0_data  = 16'h1111;
    req1_data  = 16'h2222;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (req0_ready === 1'b1 && req1_ready === 1'b1) begin
        checks++; errors++;
        $display("FAIL rr_double: got both readies, required one");
      end else if (req0_ready === 1'b1) begin
        ids[g] = 1'b0; exp_q.push_back(model(1'b0, req0_data)); g++;
      end else if (req1_ready === 1'b1) begin
        ids[g] = 1'b1; exp_q.push_back(model(1'b1, req1_data)); g++;
      end
      if (g == 4) break;
    end
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    checks++;
    if (g != 4 || ids !== exp_ids) begin
      errors++; $display("FAIL rr_order: got %0d grants ids=%b required 4 ids=%b", g, ids, exp_ids);
    end
    wait_obs(4, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rr_count: got %0d results required 4", obs_q.size()); end
    for (int i = 0; i < 4; i++) begin
      if (obs_q.size() != 0 && exp_q.size() != 0) begin
        got = obs_q.pop_front(); want = exp_q.pop_front();
        checks++;
        if (got !== want) begin errors++; $display("FAIL rr_sb[%0d]: got %h required %h", i, got, want); end
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok, stable;
    logic [15:0] w0, w1, got, want;
    logic [14:0] snap;
    logic snap_id;
    w0 = 16'($urandom_range(0, 65535));
    w1 = 16'($urandom_range(0, 65535));
    tick();
    res_ready = 1'b0;
    drive_req(1'b0, w0, ok);
    req1_data  = w1;
    req1_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (res_valid === 1'b1) break;
    end
    snap = res_data;
    snap_id = res_id;
    stable = ok && (res_valid === 1'b1);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (res_valid !== 1'b1 || res_data !== snap || res_id !== snap_id ||
          req0_ready !== 1'b0 || req1_ready !== 1'b0 || busy !== 1'b1) stable = 1'b0;
    end
    checks++;
    if (!stable) begin
      errors++; $display("FAIL bp_hold: got v=%b data=%h r1=%b required stable v=1 data=%h r1=0",
                         res_valid, res_data, req1_ready, snap);
    end
    tick();
    res_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (req1_ready !== 1'b0) begin errors++; $display("FAIL bp_done_ready: got %b required 0", req1_ready); end
    tick();
    @(negedge clk);
    checks++;
    if (req1_ready !== 1'b1) begin
      errors++; $display("FAIL bp_regrant: got req1_ready=%b required 1", req1_ready);
    end else begin
      exp_q.push_back(model(1'b1, w1));
    end
    tick();
    req1_valid = 1'b0;
    wait_obs(2, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL bp_count: got %0d results required 2", obs_q.size()); end
    for (int i = 0; i < 2; i++) begin
      if (obs_q.size() != 0 && exp_q.size() != 0) begin
        got = obs_q.pop_front(); want = exp_q.pop_front();
        checks++;
        if (got !== want) begin errors++; $display("FAIL bp_sb[%0d]: got %h required %h", i, got, want); end
      end
    end
  endtask

  task automatic test_err();
    bit ok;
    logic [15:0] got, want;
    tick();
    res_ready = 1'b1;
    kill_en = 1'b1;
    drive_req(1'b0, 16'($urandom_range(0, 65535)), ok);
    repeat (4) @(negedge clk);
    checks++;
    if (err !== 1'b0 || cal_sel !== 2'b11) begin
      errors++; $display("FAIL err_before: got err=%b sel=%b required err=0 sel=11", err, cal_sel);
    end
    @(negedge clk);
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL err_set: got %b required 1", err); end
    kill_en = 1'b0;
    wait_obs(1, ok);
    checks++;
    if (!ok || exp_q.size() == 0) begin
      errors++; $display("FAIL err_sb: got no result, required one");
    end else begin
      got = obs_q.pop_front(); want = exp_q.pop_front();
      if (got !== want) begin errors++; $display("FAIL err_sb: got %h required %h", got, want); end
    end
    tick();
    drive_req(1'b1, 16'($urandom_range(0, 65535)), ok);
    wait_obs(1, ok);
    checks++;
    if (!ok || exp_q.size() == 0) begin
      errors++; $display("FAIL err_sb2: got no result, required one");
    end else begin
      got = obs_q.pop_front(); want = exp_q.pop_front();
      if (got !== want) begin errors++; $display("FAIL err_sb2: got %h required %h", got, want); end
    end
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b required 1", err); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    logic [15:0] a, b, got, want;
    tick();
    res_ready = 1'b1;
    drive_req(1'b0, 16'h9876, ok);
    repeat (3) @(negedge clk);
    checks++;
    if (cal_sel !== 2'b10) begin errors++; $display("FAIL rm_pos: got sel=%b required 10", cal_sel); end
    rst = 1'b0;
    #1;
    checks++;
    if ({req0_ready, req1_ready, res_valid, busy, err, res_id, cal_sel, cal_d, res_data} !== 38'h0) begin
      errors++;
      $display("FAIL rm_outputs: got busy=%b err=%b sel=%b d=%h data=%h required all 0",
               busy, err, cal_sel, cal_d, res_data);
    end
    if (exp_q.size() != 0) void'(exp_q.pop_back());
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if (obs_q.size() != 0) begin
      errors++; $display("FAIL rm_noresult: got %0d results required 0", obs_q.size());
    end
    tick();
    a = 16'($urandom_range(0, 65535));
    b = 16'($urandom_range(0, 65535));
    req0_data = a; req1_data = b;
    req0_valid = 1'b1; req1_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errors++; $display("FAIL rm_tie: got r0=%b r1=%b required r0=1 r1=0", req0_ready, req1_ready);
    end else begin
      exp_q.push_back(model(1'b0, a));
    end
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_obs(1, ok);
    checks++;
    if (!ok || exp_q.size() == 0) begin
      errors++; $display("FAIL rm_sb: got no result, required one");
    end else begin
      got = obs_q.pop_front(); want = exp_q.pop_front();
      if (got !== want) begin errors++; $display("FAIL rm_sb: got %h required %h", got, want); end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    test_reset();
    test_single_req0();
    test_ready_held();
    test_round_robin();
    test_backpressure();
    test_err();
    test_reset_mid();
    repeat (5) @(negedge clk);
    checks++;
    if (exp_q.size() != 0 || obs_q.size() != 0) begin
      errors++; $display("FAIL sb_drain: got exp=%0d obs=%0d left required 0 0", exp_q.size(), obs_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
